// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared types, codes and H-bridge patterns for the move sequencer
package move_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DEAD = 2'b01,
        ST_MOVE = 2'b10,
        ST_STOP = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        MODE_FWD   = 2'b00,
        MODE_REV   = 2'b01,
        MODE_PIV_L = 2'b10,
        MODE_PIV_R = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_OBSTACLE = 2'b01,
        CAUSE_PROX     = 2'b10,
        CAUSE_CANCEL   = 2'b11
    } cause_e;

    localparam logic [3:0] HB_OFF   = 4'b0000;
    localparam logic [3:0] HB_FWD   = 4'b1010;
    localparam logic [3:0] HB_REV   = 4'b0101;
    localparam logic [3:0] HB_PIV_L = 4'b0110;
    localparam logic [3:0] HB_PIV_R = 4'b1001;

    // IN1..IN4 drive pattern for a manoeuvre code
    function automatic logic [3:0] drive_pattern(input mode_e m);
        logic [3:0] p;
        case (m)
            MODE_FWD:   p = HB_FWD;
            MODE_REV:   p = HB_REV;
            MODE_PIV_L: p = HB_PIV_L;
            MODE_PIV_R: p = HB_PIV_R;
            default:    p = HB_OFF;
        endcase
        return p;
    endfunction

    // Straight moves only care about the sensor facing the direction of travel;
    // pivots sweep both ends of the chassis so either sensor matters
    function automatic logic obstacle_relevant(input mode_e m, input logic front, input logic back);
        logic r;
        case (m)
            MODE_FWD: r = front;
            MODE_REV: r = back;
            default:  r = front | back;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchroniser followed by a stability-count debouncer
module input_debouncer #(
    parameter int W     = 4,
    parameter int TICKS = 200_000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int             CNT_W    = $clog2(TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS);

    logic [W-1:0]     s1_q, s2_q, s3_q;
    logic [W-1:0]     deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A candidate value is accepted once it has been seen unchanged for TICKS+1
    // consecutive synced samples; any change of candidate restarts the count
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (s2_q != s3_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser stages, previous-sample stage and debounce state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - timed H-bridge manoeuvre sequencer with dead-time and abort handling
module move_sequencer
    import move_pkg::*;
#(
    parameter int SENS_W         = 4,
    parameter int MOVE_TICKS     = 550_000_000,
    parameter int DEADTIME_TICKS = 10_000,
    parameter int DEBOUNCE_TICKS = 200_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              can_move,
    input  logic [1:0]        mode,
    input  logic              sensor_ir_front,
    input  logic              sensor_ir_back,
    input  logic [SENS_W-1:0] sens_ip,
    output logic [3:0]        hbridge_in,
    output logic              is_moving,
    output logic              done,
    output logic              abort,
    output logic [1:0]        abort_cause
);

    localparam int MAX_TICKS = (MOVE_TICKS > DEADTIME_TICKS) ? MOVE_TICKS : DEADTIME_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_TICKS - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);

    logic              irf_s1_q, irf_s2_q;
    logic              irb_s1_q, irb_s2_q;
    logic              can_prev_q;
    logic [SENS_W-1:0] sens_deb;

    logic              start;
    logic              abort_now;
    cause_e            abort_cause_now;
    mode_e             mode_in;

    state_e            state_q;
    mode_e             mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        hb_q;
    logic              moving_q;
    logic              done_q;
    logic              abort_q;
    cause_e            cause_q;

    // IR synchronisers and the can_move history used for rising-edge detection;
    // the history resets high so a request already asserted at reset is not a start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irf_s1_q   <= 1'b0;
            irf_s2_q   <= 1'b0;
            irb_s1_q   <= 1'b0;
            irb_s2_q   <= 1'b0;
            can_prev_q <= 1'b1;
        end else begin
            irf_s1_q   <= sensor_ir_front;
            irf_s2_q   <= irf_s1_q;
            irb_s1_q   <= sensor_ir_back;
            irb_s2_q   <= irb_s1_q;
            can_prev_q <= can_move;
        end
    end

    input_debouncer #(
        .W     (SENS_W),
        .TICKS (DEBOUNCE_TICKS)
    ) u_sens_debouncer (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (sens_ip),
        .dout    (sens_deb)
    );

    assign mode_in = mode_e'(mode);
    assign start   = can_move & ~can_prev_q;

    // Abort arbitration for DEAD and MOVE: cancel beats obstacle beats proximity
    always_comb begin
        abort_now       = 1'b1;
        abort_cause_now = CAUSE_NONE;
        if (!can_move) begin
            abort_cause_now = CAUSE_CANCEL;
        end else if (obstacle_relevant(mode_q, irf_s2_q, irb_s2_q)) begin
            abort_cause_now = CAUSE_OBSTACLE;
        end else if (|sens_deb) begin
            abort_cause_now = CAUSE_PROX;
        end else begin
            abort_now = 1'b0;
        end
    end

    // Manoeuvre FSM; every output is a register updated alongside the state so
    // the H-bridge pattern always changes on the same edge as the state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_FWD;
            cnt_q    <= '0;
            hb_q     <= HB_OFF;
            moving_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hb_q     <= HB_OFF;
                    moving_q <= 1'b0;
                    if (start) begin
                        mode_q  <= mode_in;
                        cause_q <= CAUSE_NONE;
                        cnt_q   <= '0;
                        // A blocked start goes straight to STOP without ever driving
                        if (obstacle_relevant(mode_in, irf_s2_q, irb_s2_q)) begin
                            state_q <= ST_STOP;
                            abort_q <= 1'b1;
                            cause_q <= CAUSE_OBSTACLE;
                        end else begin
                            state_q <= ST_DEAD;
                        end
                    end
                end
                ST_DEAD, ST_MOVE: begin
                    if (abort_now) begin
                        // Abort takes priority over reaching the end of the count
                        state_q  <= ST_STOP;
                        cnt_q    <= '0;
                        hb_q     <= HB_OFF;
                        moving_q <= 1'b0;
                        abort_q  <= 1'b1;
                        cause_q  <= abort_cause_now;
                    end else if (state_q == ST_DEAD) begin
                        if (cnt_q == DEAD_LAST) begin
                            state_q  <= ST_MOVE;
                            cnt_q    <= '0;
                            hb_q     <= drive_pattern(mode_q);
                            moving_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        if (cnt_q == MOVE_LAST) begin
                            state_q  <= ST_STOP;
                            cnt_q    <= '0;
                            hb_q     <= HB_OFF;
                            moving_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_STOP: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    hb_q     <= HB_OFF;
                    moving_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    hb_q     <= HB_OFF;
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign hbridge_in  = hb_q;
    assign is_moving   = moving_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign abort_cause = cause_q;

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Parametrised motion controller for the rover drive. It turns one start request into one timed H-bridge manoeuvre: forward, reverse, pivot left or pivot right. A dead-time gap precedes every drive, and the manoeuvre aborts early on a relevant IR obstacle, on a debounced proximity-sensor hit, or on cancellation. It sits between the mission/audio control logic and the H-bridge IN pins, and replaces the single-direction reverse-move block.

## Interface
- `SENS_W`, 4 — width of the proximity-sensor bus.
- `MOVE_TICKS`, 550_000_000 — drive duration in clock cycles (5.5 s at 100 MHz); must be ≥ 1.
- `DEADTIME_TICKS`, 10_000 — all-off gap before driving (100 µs); must be ≥ 1.
- `DEBOUNCE_TICKS`, 200_000 — stability time for `sens_ip` (2 ms); must be ≥ 1.

Ports:
- `clock` in 1 — system clock, rising edge. One clock domain only.
- `reset_n` in 1 — asynchronous, active-low reset.
- `can_move` in 1 — start request (level). A rising edge starts a manoeuvre; dropping it mid-manoeuvre cancels.
- `mode` in 2 — manoeuvre code, latched at start: 00 forward, 01 reverse, 10 pivot left, 11 pivot right.
- `sensor_ir_front` in 1 — asynchronous, active-high front obstacle input.
- `sensor_ir_back` in 1 — asynchronous, active-high rear obstacle input.
- `sens_ip` in `SENS_W` — asynchronous proximity sensors; any nonzero value is a hit.
- `hbridge_in` out 4 — H-bridge IN1..IN4.
- `is_moving` out 1 — high while the motors are driven (MOVE state only).
- `done` out 1 — one-cycle pulse when the full `MOVE_TICKS` completes.
- `abort` out 1 — one-cycle pulse when a manoeuvre ends early or is refused.
- `abort_cause` out 2 — 00 none, 01 obstacle, 10 proximity hit, 11 cancelled. Held until the next start.

## Operation
- Input conditioning:
  - IR inputs pass through a 2-flop synchroniser.
  - `sens_ip` passes through a 2-flop synchroniser, then a debouncer. The debounced value updates only after the synced value has been stable for `DEBOUNCE_TICKS` cycles.
- Start condition: `can_move` is high this cycle and was low the previous cycle. The previous-value register resets to 1, so `can_move` held high through reset does not start a manoeuvre.
- H-bridge patterns:
  - forward 1010, reverse 0101, pivot left 0110, pivot right 1001, off 0000.
  - Only these five values ever appear on `hbridge_in`.
  - A direction pattern never follows another pattern directly; off always intervenes for `DEADTIME_TICKS` cycles.
- Relevant obstacle by mode:
  - forward: front IR.
  - reverse: back IR.
  - pivots: front OR back IR.
- FSM states: IDLE, DEAD, MOVE, STOP.
  - IDLE: `hbridge_in` = 0000. On start, latch `mode` and clear `abort_cause`.
    - If the relevant synced IR is high at start → STOP with cause 01; motors are never driven.
    - Otherwise → DEAD.
  - DEAD: `hbridge_in` = 0000. Count `DEADTIME_TICKS` cycles, then → MOVE.
    - Abort checks apply here as in MOVE.
  - MOVE: `hbridge_in` = pattern, `is_moving` = 1. Count `MOVE_TICKS` cycles, then → STOP with `done`. Abort priority, highest first:
    - `can_move` low → cause 11.
    - relevant IR → cause 01.
    - debounced `sens_ip` ≠ 0 → cause 10.
  - STOP: `hbridge_in` = 0000 for one cycle, pulse `done` or `abort`, then → IDLE.
- Simultaneous completion and abort in the last MOVE cycle: abort wins and `done` does not pulse.
- A start while not in IDLE is ignored.
- Counter width is `$clog2(max(MOVE_TICKS, DEADTIME_TICKS)+1)`. The counter resets to 0 on every state entry and never wraps.

## Timing
- Reset values (asynchronous): state IDLE; all outputs 0; synchronisers, debouncer and counters 0; `can_move` previous-value register 1.
- A start edge sampled in cycle N gives:
  - DEAD in cycles N+1 .. N+DEADTIME_TICKS, with `hbridge_in` = 0000.
  - The drive pattern and `is_moving` from cycle N+1+DEADTIME_TICKS, for exactly `MOVE_TICKS` cycles.
  - `done` in the next cycle.
- Full manoeuvre latency from start edge to `done` = DEADTIME_TICKS + MOVE_TICKS + 1 cycles.
- IR abort: motors are off exactly 3 cycles after the raw input rises (2 synchroniser stages, 1 FSM register). `abort` pulses in that same cycle.
- `sens_ip` abort latency = 2 + DEBOUNCE_TICKS + 1 cycles, plus 1 cycle to motors off.
- Cancel: `can_move` low in cycle M gives `hbridge_in` = 0000 in M+1.
- `reset_n` asserted mid-MOVE forces `hbridge_in` to 0000 immediately (asynchronous); no pulse is issued.
- All outputs are registered.

## Structure
- Package `move_pkg` holds:
  - state enum (IDLE, DEAD, MOVE, STOP);
  - mode codes;
  - the four H-bridge patterns plus off;
  - abort-cause codes.
- Sub-module `input_debouncer`:
  - parameters `W` and `TICKS`;
  - contains the 2-flop synchroniser and the stability counter;
  - instantiated once for `sens_ip`, with `W` = `SENS_W`.
- IR synchronisers stay inline in the top level.

## Test plan
All scenarios use `MOVE_TICKS`=20, `DEADTIME_TICKS`=4, `DEBOUNCE_TICKS`=3.
- Forward run: `mode`=00, pulse `can_move` high and hold it.
  - Required: 4 cycles of 0000, then 20 cycles of 1010 with `is_moving`=1, then a `done` pulse and `abort_cause`=00.
- Reverse with rear obstacle: `mode`=01; raise `sensor_ir_back` at MOVE cycle 5.
  - Required: 0000 exactly 3 cycles later, `abort` pulse, `abort_cause`=01, no `done`.
- Blocked start and cancel:
  - `mode`=00 with `sensor_ir_front` already high at start → no 1010 ever, `abort` pulse, cause 01.
  - Separately, drop `can_move` during MOVE → 0000 the next cycle, cause 11.
- Proximity debounce:
  - `sens_ip`=0001 for 2 cycles → no abort.
  - `sens_ip`=1001 held → abort at 2+3+1+1 cycles, cause 10.
- Boundaries:
  - Abort and completion in the same final MOVE cycle → `abort` only.
  - `reset_n` low mid-MOVE → `hbridge_in`=0000 without waiting for a clock edge.
  - `can_move` held high through reset release → no start until it falls and rises again.
- Pivot patterns: `mode`=10 → 0110, `mode`=11 → 1001.
  - Back-to-back starts must always show ≥ 4 cycles of 0000 between patterns.
